// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//             7-segment display. One external DECODER7 is shared by all
//             digits. Each digit slot starts with a blanking window. The
//             displayed value is double-buffered so that updates only take
//             effect on frame boundaries.
//  Ports    : i_clk      - system clock
//             i_rst_n    - asynchronous active-low reset
//             i_en       - 1 = scan, 0 = display dark
//             i_value    - four hex digits, [3:0] is rightmost (o_an[0])
//             i_dp_in    - decimal point per digit, 1 = lit
//             i_load     - one-cycle strobe capturing i_value / i_dp_in
//             i_dec_led  - segments from DECODER7 {a..g,dp}, active-low
//             o_nibble   - nibble to DECODER7
//             o_led      - segments to pads, active-low
//             o_an       - anodes, active-low, one-hot-low while showing
//             o_frame    - one-cycle pulse on digit index wrap 3 -> 0
//             o_pend     - a loaded value waits for the next frame boundary
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp_in,
    input  logic        i_load,
    input  logic [7:0]  i_dec_led,
    output logic [3:0]  o_nibble,
    output logic [7:0]  o_led,
    output logic [3:0]  o_an,
    output logic        o_frame,
    output logic        o_pend
);

    localparam int              C_CW      = $clog2(SCAN_DIV);
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(SCAN_DIV - 1);
    localparam logic [C_CW-1:0] C_BLANK   = C_CW'(BLANK_CYC);

    // Scan state: r_run selects IDLE vs. scanning; within a scan, r_cnt
    // splits each slot into BLANK (r_cnt < C_BLANK) and SHOW.
    logic            r_run;
    logic [C_CW-1:0] r_cnt;
    logic [1:0]      r_idx;
    logic            r_frame;
    logic [15:0]     r_shadow;
    logic [3:0]      r_sdp;
    logic [15:0]     r_pval;
    logic [3:0]      r_pdp;
    logic            r_pend;

    logic            w_run_nxt;
    logic [C_CW-1:0] w_cnt_nxt;
    logic [1:0]      w_idx_nxt;
    logic            w_frame_nxt;
    logic [15:0]     w_shadow_nxt;
    logic [3:0]      w_sdp_nxt;
    logic [15:0]     w_pval_nxt;
    logic [3:0]      w_pdp_nxt;
    logic            w_pend_nxt;

    logic            w_wrap;
    logic            w_boundary;
    logic            w_show;

    assign w_wrap     = (r_cnt == C_CNT_MAX);
    // Last cycle of digit 3 while scanning continues: the frame boundary.
    assign w_boundary = r_run && i_en && w_wrap && (r_idx == 2'd3);
    assign w_show     = r_run && (r_cnt >= C_BLANK);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_frame  <= 1'b0;
            r_shadow <= 16'h0000;
            r_sdp    <= 4'h0;
            r_pval   <= 16'h0000;
            r_pdp    <= 4'h0;
            r_pend   <= 1'b0;
        end else begin
            r_run    <= w_run_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_frame  <= w_frame_nxt;
            r_shadow <= w_shadow_nxt;
            r_sdp    <= w_sdp_nxt;
            r_pval   <= w_pval_nxt;
            r_pdp    <= w_pdp_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_run_nxt    = r_run;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_frame_nxt  = 1'b0;
        w_shadow_nxt = r_shadow;
        w_sdp_nxt    = r_sdp;
        w_pval_nxt   = r_pval;
        w_pdp_nxt    = r_pdp;
        w_pend_nxt   = r_pend;

        // Scan sequencing
        if (!r_run) begin
            if (i_en) begin
                w_run_nxt = 1'b1;
                w_cnt_nxt = '0;
                w_idx_nxt = 2'd0;
            end
        end else if (!i_en) begin
            // Abandoning a scan never produces a frame pulse.
            w_run_nxt = 1'b0;
            w_cnt_nxt = '0;
            w_idx_nxt = 2'd0;
        end else if (w_wrap) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_frame_nxt = (r_idx == 2'd3);
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end

        // Double buffering. While idle, or exactly on the boundary, a load
        // can go straight to the shadow without tearing a frame; otherwise
        // it parks in the pending registers (last load wins).
        if (!r_run || w_boundary) begin
            if (i_load) begin
                w_shadow_nxt = i_value;
                w_sdp_nxt    = i_dp_in;
                w_pend_nxt   = 1'b0;
            end else if (w_boundary && r_pend) begin
                w_shadow_nxt = r_pval;
                w_sdp_nxt    = r_pdp;
                w_pend_nxt   = 1'b0;
            end
        end else if (i_load) begin
            w_pval_nxt = i_value;
            w_pdp_nxt  = i_dp_in;
            w_pend_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode; only i_dec_led reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        o_nibble = r_shadow[{r_idx, 2'b00} +: 4];
        o_an     = 4'hF;
        o_led    = 8'hFF;
        if (w_show) begin
            o_an  = ~(4'b0001 << r_idx);
            o_led = {i_dec_led[7:1], i_dec_led[0] & ~r_sdp[r_idx]};
        end
        o_frame = r_frame;
        o_pend  = r_pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Self-checking bench for seg7_scan_ctrl (SCAN_DIV=8,
//             BLANK_CYC=2). A reference model computes the expected display
//             from elapsed time since enable; expectations are queued and
//             a separate monitor compares them on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FL = 4 * SD;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [7:0]  dec_led;
    logic [3:0]  nibble;
    logic [7:0]  led;
    logic [3:0]  an;
    logic        frame;
    logic        pend;

    int errors = 0;
    int checks = 0;

    // {an, led, nibble, frame, pend}
    logic [17:0] exp_q[$];

    // Reference model state
    bit        m_run;
    int        m_t;
    bit [15:0] m_shadow;
    bit [3:0]  m_sdp;
    bit [15:0] m_pv;
    bit [3:0]  m_pdp;
    bit        m_pend;

    seg7_scan_ctrl #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BL)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_value   (value),
        .i_dp_in   (dp_in),
        .i_load    (load),
        .i_dec_led (dec_led),
        .o_nibble  (nibble),
        .o_led     (led),
        .o_an      (an),
        .o_frame   (frame),
        .o_pend    (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DECODER7, active-low {a..g,dp}, dp pin inactive.
    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001; 4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010; 4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100; 4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000; 4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000; 4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000; 4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001; 4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000; default: s = 7'b0111000;
        endcase
        return {s, 1'b1};
    endfunction

    assign dec_led = seg7(nibble);

    function automatic logic [17:0] model_out();
        int         slot;
        bit         show;
        logic [3:0] n;
        logic [3:0] a;
        logic [7:0] l;
        bit         f;
        slot = (m_t / SD) % 4;
        show = m_run && ((m_t % SD) >= BL);
        n    = 4'((m_shadow >> (4 * slot)) & 16'hF);
        a    = 4'hF;
        l    = 8'hFF;
        if (show) begin
            a    = ~(4'(1 << slot));
            l    = seg7(n);
            if (m_sdp[slot]) l[0] = 1'b0;
        end
        f = m_run && (m_t > 0) && ((m_t % FL) == 0);
        return {a, l, n, f, m_pend};
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_shadow = 0; m_sdp = 0;
        m_pv = 0; m_pdp = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit e, input bit ld,
                              input bit [15:0] v, input bit [3:0] d);
        if (!m_run) begin
            if (ld) begin m_shadow = v; m_sdp = d; m_pend = 0; end
            if (e) begin m_run = 1; m_t = 0; end
        end else if (!e) begin
            if (ld) begin m_pv = v; m_pdp = d; m_pend = 1; end
            m_run = 0;
            m_t   = 0;
        end else begin
            if (((m_t + 1) % FL) == 0) begin
                if (ld) begin
                    m_shadow = v; m_sdp = d; m_pend = 0;
                end else if (m_pend) begin
                    m_shadow = m_pv; m_sdp = m_pdp; m_pend = 0;
                end
            end else if (ld) begin
                m_pv = v; m_pdp = d; m_pend = 1;
            end
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [17:0] act,
                         input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got an=%b led=%h nib=%h frame=%b pend=%b, expected an=%b led=%h nib=%h frame=%b pend=%b",
                     name, $time, act[17:14], act[13:6], act[5:2], act[1], act[0],
                     exp[17:14], exp[13:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Apply inputs between edges, clock once, queue the expected response.
    task automatic tick(input bit e, input bit ld,
                        input bit [15:0] v, input bit [3:0] d);
        en = e; load = ld; value = v; dp_in = d;
        @(posedge clk);
        model_step(e, ld, v, d);
        exp_q.push_back(model_out());
        #1;
        load = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 16'h0, 4'h0);
    endtask

    // Asynchronous reset pulse placed strictly between clock edges.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1 check("async_reset", {an, led, nibble, frame, pend},
                 {4'hF, 8'hFF, 4'h0, 1'b0, 1'b0});
        #1 rst_n = 1'b1;
        exp_q.delete();
        model_reset();
        exp_q.push_back(model_out());
    endtask

    // Monitor: decoupled from stimulus, compares every displayed cycle.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scan", {an, led, nibble, frame, pend}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
        model_reset();
        #3;
        check("reset_state", {an, led, nibble, frame, pend},
              {4'hF, 8'hFF, 4'h0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Enable straight out of reset, then stop.
        run_n(12);
        tick(0, 0, 16'h0, 4'h0);
        tick(0, 0, 16'h0, 4'h0);

        // Idle load, then two full frames.
        tick(0, 1, 16'h1234, 4'h0);
        run_n(2 * FL + 3);

        // Mid-frame load during digit 1, then a second load overwrites it.
        while (!(m_run && ((m_t / SD) % 4) == 1 && (m_t % SD) == 3))
            run_n(1);
        tick(1, 1, 16'h5555, 4'h1);
        run_n(2);
        tick(1, 1, 16'hABCD, 4'h0);
        run_n(FL + 4);

        // Drop enable while showing digit 2, then re-enable.
        while (!(m_run && ((m_t / SD) % 4) == 2 && (m_t % SD) == 4))
            run_n(1);
        tick(0, 0, 16'h0, 4'h0);
        run_n(SD + 2);

        // Decimal point on digit 2, landing at the next boundary.
        tick(1, 1, 16'h9876, 4'b0100);
        run_n(2 * FL);

        // Pending load then a load exactly in the boundary cycle.
        tick(1, 1, 16'h1111, 4'hF);
        while (!(m_run && ((m_t + 1) % FL) == 0)) run_n(1);
        tick(1, 1, 16'hC0DE, 4'b1001);
        run_n(FL + 2);

        // Asynchronous reset while showing.
        while (!(m_run && (m_t % SD) == 5)) run_n(1);
        reset_pulse();
        run_n(FL + 5);

        // Randomized traffic, with an occasional reset pulse.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_pulse();
            end else begin
                tick(($urandom_range(0, 99) < 95) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                     16'($urandom), 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
